// File: rtl/mul_iterative_unit.sv
// Sequential shift-add multiplier: one accumulate/shift step per clock, 2*WIDTH-bit product.
// Optional MUL_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are all zero.
module mul_iterative_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic               iSigned,
  input  logic [WIDTH-1:0]   iA,
  input  logic [WIDTH-1:0]   iB,
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oResult
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplr;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic                 sign;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 start_sign;
  logic [2*WIDTH-1:0]   partial;
  logic                 accept;
  logic                 finish;

  // The negated most-negative operand reads correctly as an unsigned WIDTH-bit magnitude.
  assign mag_a      = (iSigned && iA[WIDTH-1]) ? (~iA + 1'b1) : iA;
  assign mag_b      = (iSigned && iB[WIDTH-1]) ? (~iB + 1'b1) : iB;
  assign start_sign = iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
  assign partial    = mplr[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
  assign accept     = iStart && (state != BUSY);

  // The final cycle in BUSY is a no-add step: the multiplier has already shifted out to zero.
`ifdef MUL_EARLY_EXIT_EN
  assign finish = (cnt == CNT_W'(WIDTH)) || ((cnt != '0) && (mplr == '0));
`else
  assign finish = (cnt == CNT_W'(WIDTH));
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
      sign    <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oResult <= '0;
    end else begin
      oDone <= 1'b0;
      if (accept) begin
        mcand <= mag_a;
        mplr  <= mag_b;
        sign  <= start_sign;
        acc   <= '0;
        cnt   <= '0;
        oBusy <= 1'b1;
        state <= BUSY;
      end else begin
        case (state)
          BUSY: begin
            if (finish) begin
              oResult <= sign ? (~acc + 1'b1) : acc;
              oDone   <= 1'b1;
              state   <= DONE;
            end else begin
              acc  <= acc + partial;
              mplr <= mplr >> 1;
              cnt  <= cnt + CNT_W'(1);
            end
          end
          DONE: begin
            oBusy <= 1'b0;
            state <= IDLE;
          end
          default: begin
            oBusy <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_iterative_unit.sv
// Directed bench for mul_iterative_unit: vector table plus back-to-back, busy-start and reset-abort sequences.
module tb_mul_iterative_unit;

  localparam int WIDTH = 16;
`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  logic              Clock;
  logic              Reset;
  logic              iStart;
  logic              iSigned;
  logic [WIDTH-1:0]  iA;
  logic [WIDTH-1:0]  iB;
  logic              oBusy;
  logic              oDone;
  logic [2*WIDTH-1:0] oResult;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs[10];

  mul_iterative_unit #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (iStart),
    .iSigned (iSigned),
    .iA      (iA),
    .iB      (iB),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oResult (oResult)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Cycles from the start edge to the oDone cycle, derived from the multiplier magnitude.
  function automatic int expLatency(input logic [15:0] b, input logic s);
    logic [15:0] m;
    int hi;
    m  = (s && b[15]) ? (~b + 16'd1) : b;
    hi = -1;
    for (int i = 0; i < 16; i++) if (m[i]) hi = i;
    if (EARLY_EXIT) return (hi < 0) ? 2 : hi + 2;
    return 17;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issues one operation from just after an edge; returns the observed latency (-1 on timeout).
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic s,
                               output int lat, output logic [31:0] res);
    iA      = a;
    iB      = b;
    iSigned = s;
    iStart  = 1'b1;
    @(posedge Clock);
    #1;
    iStart  = 1'b0;
    iA      = 16'hDEAD;
    iB      = 16'hBEEF;
    iSigned = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge Clock);
      #1;
      if (oDone) begin
        lat = n;
        break;
      end
    end
    res = oResult;
  endtask

  int          lat;
  logic [31:0] res;
  int          sawDone;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    iStart  = 1'b0;
    iSigned = 1'b0;
    iA      = '0;
    iB      = '0;
    Reset   = 1'b1;

    vecs[0] = '{16'h0003, 16'h0005, 1'b0, 32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vecs[2] = '{16'hFFF9, 16'h0006, 1'b1, 32'hFFFFFFD6};
    vecs[3] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vecs[4] = '{16'h1234, 16'h0000, 1'b0, 32'h00000000};
    vecs[5] = '{16'h0007, 16'h0001, 1'b0, 32'h00000007};
    vecs[6] = '{16'h8000, 16'hFFFF, 1'b1, 32'h00008000};
    vecs[7] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    vecs[9] = '{16'h00FF, 16'h0100, 1'b0, 32'h0000FF00};

    #2;
    checkOutput("reset_busy",   {31'd0, oBusy}, 32'd0);
    checkOutput("reset_done",   {31'd0, oDone}, 32'd0);
    checkOutput("reset_result", oResult,        32'd0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(posedge Clock);
    #1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, lat, res);
      checkOutput($sformatf("vec%0d_latency", i), lat, expLatency(vecs[i].b, vecs[i].s));
      checkOutput($sformatf("vec%0d_result", i), res, vecs[i].expected);
      @(posedge Clock);
      #1;
      checkOutput($sformatf("vec%0d_done_pulse", i), {31'd0, oDone}, 32'd0);
      checkOutput($sformatf("vec%0d_idle_busy", i), {31'd0, oBusy}, 32'd0);
    end

    // Back-to-back: second start issued in the oDone cycle of the first.
    applyStimulus(16'd3, 16'd5, 1'b0, lat, res);
    checkOutput("b2b_first_result", res, 32'h0000000F);
    applyStimulus(16'd2, 16'd9, 1'b0, lat, res);
    checkOutput("b2b_latency", lat, expLatency(16'd9, 1'b0));
    checkOutput("b2b_result", res, 32'h00000012);

    // Start pulses while busy must be ignored; the old product stays visible meanwhile.
    @(posedge Clock);
    #1;
    iA = 16'd100; iB = 16'd3; iSigned = 1'b0; iStart = 1'b1;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    checkOutput("busy_after_start", {31'd0, oBusy}, 32'd1);
    checkOutput("result_held", oResult, 32'h00000012);
    @(posedge Clock);
    #1;
    iA = 16'd7; iB = 16'hFFFF; iSigned = 1'b1; iStart = 1'b1;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    lat = -1;
    for (int n = 3; n <= 40; n++) begin
      @(posedge Clock);
      #1;
      if (oDone) begin
        lat = n;
        break;
      end
    end
    checkOutput("busy_start_latency", lat, expLatency(16'd3, 1'b0));
    checkOutput("busy_start_result", oResult, 32'h0000012C);

    // Reset abort in the middle of 100*100.
    @(posedge Clock);
    #1;
    iA = 16'd100; iB = 16'd100; iSigned = 1'b0; iStart = 1'b1;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    repeat (7) @(posedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    checkOutput("abort_busy",   {31'd0, oBusy}, 32'd0);
    checkOutput("abort_done",   {31'd0, oDone}, 32'd0);
    checkOutput("abort_result", oResult,        32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    sawDone = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge Clock);
      #1;
      if (oDone || oBusy) sawDone = 1;
    end
    checkOutput("abort_no_done", sawDone, 0);
    checkOutput("abort_result_kept", oResult, 32'd0);
    applyStimulus(16'd4, 16'd4, 1'b0, lat, res);
    checkOutput("post_abort_latency", lat, expLatency(16'd4, 1'b0));
    checkOutput("post_abort_result", res, 32'h00000010);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
